wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the RISC-V core: accepts retiring instructions from the MEM stage over a valid/ready handshake and drives the register file write port (`we`/`waddr`/`wdata`). ALU results are written one cycle after acceptance. Loads park in a wait state until the data-memory response arrives, then the byte, halfword or word is extracted, sign- or zero-extended and written. The stage also handles flush, a load-response timeout and x0 write suppression.

## Interface
Parameters:
- `LD_TIMEOUT`, 255: max cycles spent in WAIT_LD before abort; 1..255, 8-bit counter.

Ports:
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous, active-low reset (0 = reset).
- `in_valid` input 1: MEM-stage instruction valid.
- `in_ready` output 1: stage can accept; high only in IDLE.
- `in_wreg` input 1: instruction writes a destination register.
- `in_wd` input 5: destination register index.
- `in_wdata` input 32: ALU result (non-load).
- `in_is_load` input 1: instruction is a load.
- `in_load_type` input 3: load funct3.
- `in_addr_lo` input 2: load byte address bits [1:0].
- `flush` input 1: discard accepted/pending instruction.
- `dmem_rvalid` input 1: data-memory read response valid.
- `dmem_rdata` input 32: aligned data-memory word.
- `we` output 1: regfile write enable, one-cycle pulse.
- `waddr` output 5: regfile write index.
- `wdata` output 32: regfile write data.
- `ld_timeout` output 1: one-cycle pulse, load aborted by timeout.
- `load_misalign` output 1: one-cycle pulse; present only with `WB_MISALIGN_CHK_EN`, tied 0 otherwise.

## Operation
- States: IDLE, WAIT_LD. Reset → IDLE. All outputs reset to 0, counter 0.
- IDLE, `in_valid`=1, `flush`=0, `in_is_load`=0: next cycle `we`=`in_wreg` && (`in_wd`!=0), `waddr`=`in_wd`, `wdata`=`in_wdata`. Stay IDLE.
- IDLE, `in_valid`=1, `flush`=0, `in_is_load`=1: latch `in_wd`, `in_wreg`, `in_load_type`, `in_addr_lo`; go WAIT_LD; clear counter.
- WAIT_LD, `dmem_rvalid`=1: next cycle `we`=latched wreg && wd!=0, `wdata`=extracted; go IDLE.
- Extraction: byte = `dmem_rdata[8*addr_lo +: 8]`; half = `dmem_rdata[16*addr_lo[1] +: 16]`.
  - 000 LB sign-extend byte; 100 LBU zero-extend byte.
  - 001 LH sign-extend half; 101 LHU zero-extend half.
  - 010 LW full word; 011/110/111 treated as LW.
- WAIT_LD without `dmem_rvalid`: counter +1 per cycle; when counter reaches `LD_TIMEOUT`, go IDLE, pulse `ld_timeout`, no write.
- `flush`=1: in IDLE the incoming instruction is dropped; in WAIT_LD, return to IDLE with no write. Flush beats a simultaneous `dmem_rvalid` or timeout: no write, no `ld_timeout`.
- `dmem_rvalid` in IDLE is ignored.
- `we` is 0 in every cycle not listed above; `waddr`/`wdata` hold their last value when `we`=0.
- `rst`=0 in any state: IDLE next cycle, pending load discarded, no write.

## Timing
- ALU path latency: 1 cycle, accept edge → `we` high.
- Load path latency: 1 cycle, `dmem_rvalid` edge → `we` high.
- Back-to-back ALU instructions are accepted every cycle, 1 write/cycle.
- `in_ready` is combinational from state only, not from `in_valid`.
- Earliest new accept after a load: the cycle the load's `we` is high.
- Timeout: `ld_timeout` is high exactly `LD_TIMEOUT`+1 cycles after the load-accept edge.

## Configuration
- `WB_MISALIGN_CHK_EN` defined: LH/LHU with `addr_lo[0]`=1, or LW with `addr_lo`!=0, complete on `dmem_rvalid` with `we`=0 and pulse `load_misalign` in the cycle `we` would have been high.
- Not defined: no check; extraction uses address bits as above, and `load_misalign` is tied 0.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → `we`=0, `waddr`=0, `wdata`=0, `in_ready`=1.
- ALU write: accept wd=5, wdata=0xDEADBEEF → next cycle `we`=1, `waddr`=5, `wdata`=0xDEADBEEF; then wd=0 → `we`=0.
- Loads: rdata=0x80F0_7F81; LB addr_lo=0 → 0xFFFFFF81; LBU addr_lo=3 → 0x00000080; LH addr_lo=2 → 0xFFFF80F0; LHU addr_lo=0 → 0x00007F81; LW → 0x80F07F81.
- Back-pressure: load accepted, `dmem_rvalid` 3 cycles later → `in_ready`=0 for those cycles, then the write occurs and the next ALU op is accepted the same cycle.
- Flush vs response: `flush` and `dmem_rvalid` in the same WAIT_LD cycle → no write, back in IDLE; separately, `LD_TIMEOUT`=4 with no response → `ld_timeout` pulses 5 cycles after accept, no write.
- `WB_MISALIGN_CHK_EN`: LW with addr_lo=2 → `we`=0, `load_misalign`=1 for one cycle.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and aligned/extended load data into the register file.
// Optional macro WB_MISALIGN_CHK_EN suppresses writes of misaligned LH/LHU/LW and pulses load_misalign.
module wb_stage #(
  parameter int unsigned LD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wreg,
  input  logic [4:0]  in_wd,
  input  logic [31:0] in_wdata,
  input  logic        in_is_load,
  input  logic [2:0]  in_load_type,
  input  logic [1:0]  in_addr_lo,
  input  logic        flush,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        ld_timeout,
  output logic        load_misalign
);

  typedef enum logic {IDLE, WAIT_LD} state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(LD_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wreg_q, wreg_d;
  logic [4:0]  wd_q, wd_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [1:0]  alo_q, alo_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        tmo_q, tmo_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val;
`ifdef WB_MISALIGN_CHK_EN
  logic        mis_q, mis_d;
  logic        misaligned;
`endif

  // Extraction works on the latched load attributes, since the response arrives later.
  always_comb begin
    unique case (alo_q)
      2'd0:    byte_v = dmem_rdata[7:0];
      2'd1:    byte_v = dmem_rdata[15:8];
      2'd2:    byte_v = dmem_rdata[23:16];
      default: byte_v = dmem_rdata[31:24];
    endcase
    half_v = alo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (ltype_q)
      3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  ld_val = {24'd0, byte_v};
      3'b001:  ld_val = {{16{half_v[15]}}, half_v};
      3'b101:  ld_val = {16'd0, half_v};
      default: ld_val = dmem_rdata;
    endcase
  end

`ifdef WB_MISALIGN_CHK_EN
  assign misaligned = ((ltype_q[1:0] == 2'b01) && alo_q[0]) ||
                      (ltype_q[1] && (alo_q != 2'd0));
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    ltype_d = ltype_q;
    alo_d   = alo_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    tmo_d   = 1'b0;
`ifdef WB_MISALIGN_CHK_EN
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (in_is_load) begin
            wreg_d  = in_wreg;
            wd_d    = in_wd;
            ltype_d = in_load_type;
            alo_d   = in_addr_lo;
            cnt_d   = 8'd0;
            state_d = WAIT_LD;
          end else begin
            we_d = in_wreg && (in_wd != 5'd0);
            if (we_d) begin
              waddr_d = in_wd;
              wdata_d = in_wdata;
            end
          end
        end
      end
      WAIT_LD: begin
        // Flush wins over a response or timeout arriving in the same cycle.
        if (flush) begin
          state_d = IDLE;
        end else if (dmem_rvalid) begin
          state_d = IDLE;
`ifdef WB_MISALIGN_CHK_EN
          mis_d = misaligned;
          we_d  = !misaligned && wreg_q && (wd_q != 5'd0);
`else
          we_d  = wreg_q && (wd_q != 5'd0);
`endif
          if (we_d) begin
            waddr_d = wd_q;
            wdata_d = ld_val;
          end
        end else if (cnt_q == TMO_LIMIT) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      wreg_q  <= 1'b0;
      wd_q    <= 5'd0;
      ltype_q <= 3'd0;
      alo_q   <= 2'd0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      tmo_q   <= 1'b0;
`ifdef WB_MISALIGN_CHK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
      ltype_q <= ltype_d;
      alo_q   <= alo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
`ifdef WB_MISALIGN_CHK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign ld_timeout = tmo_q;
`ifdef WB_MISALIGN_CHK_EN
  assign load_misalign = mis_q;
`else
  assign load_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: transaction-level model checked every cycle, plus directed literal expectations.
module tb_wb_stage;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wreg, in_is_load, flush, dmem_rvalid;
  logic [4:0]  in_wd;
  logic [31:0] in_wdata, dmem_rdata;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_lo;
  logic        we, ld_timeout, load_misalign;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_errors = 0;

  wb_stage #(.LD_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wreg(in_wreg), .in_wd(in_wd),
    .in_wdata(in_wdata), .in_is_load(in_is_load), .in_load_type(in_load_type),
    .in_addr_lo(in_addr_lo), .flush(flush), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .we(we), .waddr(waddr), .wdata(wdata),
    .ld_timeout(ld_timeout), .load_misalign(load_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load semantics from plain arithmetic on the response word.
  function automatic logic [31:0] load_value(input logic [2:0] t, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * int'(a))) & 32'hFF;
    h = (d >> (16 * (int'(a) / 2))) & 32'hFFFF;
    case (t)
      3'b000:  return (b >= 32'h80)   ? b - 32'h100   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  function automatic bit is_misaligned(input logic [2:0] t, input logic [1:0] a);
`ifdef WB_MISALIGN_CHK_EN
    return ((t[1:0] == 2'b01) && a[0]) || (t[1] && (a != 2'd0));
`else
    return 1'b0;
`endif
  endfunction

  // Model: one outstanding load with an age in cycles since acceptance.
  bit          m_pending = 0;
  int          m_age = 0;
  logic        m_wreg;
  logic [4:0]  m_wd;
  logic [2:0]  m_type;
  logic [1:0]  m_alo;
  logic        exp_we = 0, exp_tmo = 0, exp_mis = 0;
  logic [4:0]  exp_waddr = 0;
  logic [31:0] exp_wdata = 0;

  always @(posedge clk) begin
    exp_we = 0; exp_tmo = 0; exp_mis = 0;
    if (!rst) begin
      m_pending = 0; m_age = 0; exp_waddr = 0; exp_wdata = 0;
    end else if (!m_pending) begin
      if (in_valid && !flush) begin
        if (in_is_load) begin
          m_pending = 1; m_age = 0;
          m_wreg = in_wreg; m_wd = in_wd; m_type = in_load_type; m_alo = in_addr_lo;
        end else if (in_wreg && in_wd != 0) begin
          exp_we = 1; exp_waddr = in_wd; exp_wdata = in_wdata;
        end
      end
    end else begin
      m_age++;
      if (flush) begin
        m_pending = 0;
      end else if (dmem_rvalid) begin
        m_pending = 0;
        if (is_misaligned(m_type, m_alo)) exp_mis = 1;
        else if (m_wreg && m_wd != 0) begin
          exp_we = 1; exp_waddr = m_wd; exp_wdata = load_value(m_type, m_alo, dmem_rdata);
        end
      end else if (m_age == TMO + 1) begin
        m_pending = 0; exp_tmo = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("m_we", we, exp_we);
    check("m_waddr", waddr, exp_waddr);
    check("m_wdata", wdata, exp_wdata);
    check("m_ready", in_ready, !m_pending);
    check("m_tmo", ld_timeout, exp_tmo);
    check("m_mis", load_misalign, exp_mis);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic alu(input logic wreg, input logic [4:0] wd, input logic [31:0] d, input logic fl);
    in_valid = 1; in_is_load = 0; in_wreg = wreg; in_wd = wd; in_wdata = d; flush = fl;
    tick();
    in_valid = 0; flush = 0;
  endtask

  task automatic do_load(input logic [2:0] t, input logic [1:0] a, input logic [4:0] wd,
                         input logic [31:0] d, input int delay);
    in_valid = 1; in_is_load = 1; in_wreg = 1; in_wd = wd; in_load_type = t; in_addr_lo = a;
    in_wdata = 32'h1234_5678;
    tick();
    in_valid = 0; in_is_load = 0;
    for (int i = 0; i < delay; i++) begin
      check("bp_ready", in_ready, 0);
      tick();
    end
    check("wait_ready", in_ready, 0);
    dmem_rvalid = 1; dmem_rdata = d;
    tick();
    dmem_rvalid = 0;
  endtask

  localparam logic [31:0] RD = 32'h80F0_7F81;

  initial begin
    rst = 0; in_valid = 0; in_wreg = 0; in_wd = 0; in_wdata = 0; in_is_load = 0;
    in_load_type = 0; in_addr_lo = 0; flush = 0; dmem_rvalid = 0; dmem_rdata = 0;
    tick(); tick();
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_ready", in_ready, 1);
    rst = 1;
    tick();

    alu(1, 5'd5, 32'hDEAD_BEEF, 0);
    check("alu_we", we, 1);
    check("alu_waddr", waddr, 5);
    check("alu_wdata", wdata, 32'hDEAD_BEEF);
    alu(1, 5'd0, 32'h1111_1111, 0);
    check("x0_we", we, 0);
    check("x0_hold", waddr, 5);
    alu(1, 5'd7, 32'h2222_2222, 1);
    check("flush_idle_we", we, 0);
    alu(1, 5'd8, 32'h0000_0001, 0);
    alu(1, 5'd9, 32'h0000_0002, 0);
    check("b2b_waddr", waddr, 9);

    do_load(3'b000, 2'd0, 5'd10, RD, 0);
    check("lb", wdata, 32'hFFFF_FF81);
    do_load(3'b100, 2'd3, 5'd10, RD, 0);
    check("lbu", wdata, 32'h0000_0080);
    do_load(3'b001, 2'd2, 5'd10, RD, 1);
    check("lh", wdata, 32'hFFFF_80F0);
    do_load(3'b101, 2'd0, 5'd10, RD, 0);
    check("lhu", wdata, 32'h0000_7F81);
    do_load(3'b010, 2'd0, 5'd11, RD, 0);
    check("lw", wdata, 32'h80F0_7F81);
    check("lw_waddr", waddr, 11);

    // Back-pressure: the write cycle also accepts the next ALU op.
    do_load(3'b110, 2'd0, 5'd12, 32'h0BAD_F00D, 3);
    check("bp_we", we, 1);
    check("bp_ready_at_write", in_ready, 1);
    alu(1, 5'd13, 32'hCAFE_0013, 0);
    check("bp_next_we", we, 1);
    check("bp_next_waddr", waddr, 13);

    do_load(3'b010, 2'd0, 5'd0, RD, 0);
    check("ld_x0_we", we, 0);

    // Flush together with the response.
    in_valid = 1; in_is_load = 1; in_wreg = 1; in_wd = 5'd14; in_load_type = 3'b010; in_addr_lo = 0;
    tick();
    in_valid = 0; in_is_load = 0;
    flush = 1; dmem_rvalid = 1; dmem_rdata = 32'h5555_5555;
    tick();
    flush = 0; dmem_rvalid = 0;
    check("flush_rv_we", we, 0);
    check("flush_rv_ready", in_ready, 1);

    // Timeout latency measured in edges after the accept edge.
    in_valid = 1; in_is_load = 1; in_wd = 5'd15;
    tick();
    in_valid = 0; in_is_load = 0;
    begin
      int n;
      n = 0;
      while (n < 20) begin
        tick(); n++;
        if (ld_timeout) break;
      end
      check("tmo_latency", n, TMO + 1);
      check("tmo_no_we", we, 0);
      tick();
      check("tmo_one_pulse", ld_timeout, 0);
      check("tmo_ready", in_ready, 1);
    end

    // Response while idle does nothing.
    dmem_rvalid = 1; tick(); dmem_rvalid = 0;
    check("idle_rv_we", we, 0);

    do_load(3'b010, 2'd2, 5'd16, RD, 0);
`ifdef WB_MISALIGN_CHK_EN
    check("mis_we", we, 0);
    check("mis_pulse", load_misalign, 1);
    tick();
    check("mis_one_pulse", load_misalign, 0);
`else
    check("lw_a2_wdata", wdata, 32'h80F0_7F81);
    check("lw_a2_nomis", load_misalign, 0);
`endif

    // Reset while a load waits.
    in_valid = 1; in_is_load = 1; in_wd = 5'd17; tick(); in_valid = 0; in_is_load = 0;
    rst = 0; dmem_rvalid = 1; tick(); rst = 1; dmem_rvalid = 0;
    check("rst_wait_we", we, 0);
    check("rst_wait_ready", in_ready, 1);

    // Randomised mix, checked by the model only.
    for (int i = 0; i < 300; i++) begin
      rst          = ($urandom_range(0, 49) != 0);
      in_valid     = $urandom_range(0, 1);
      in_is_load   = ($urandom_range(0, 2) == 0);
      in_wreg      = ($urandom_range(0, 7) != 0);
      in_wd        = 5'($urandom_range(0, 31));
      in_wdata     = $urandom;
      in_load_type = 3'($urandom_range(0, 7));
      in_addr_lo   = 2'($urandom_range(0, 3));
      flush        = ($urandom_range(0, 11) == 0);
      dmem_rvalid  = ($urandom_range(0, 3) == 0);
      dmem_rdata   = $urandom;
      tick();
    end
    rst = 1; in_valid = 0; flush = 0; dmem_rvalid = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
